// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock time-setting controller: FSM state encoding,
// mode field width and a small elaboration-time helper.
package clock_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// Key front end: 2-flop synchronizer, rising-edge detect and optional
// hold-to-repeat pulse generator.
module key_conditioner
    import clock_ctrl_pkg::*;
#(
    parameter bit REPEAT_EN  = 1'b0,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    input  logic restart_i,
    output logic pulse_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise;

    always_comb begin
        sync1_d = key_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

    generate
        if (REPEAT_EN) begin : g_rpt
            localparam int RPT_MAX = max_int(REPEAT_DLY, REPEAT_PER);
            localparam int CNT_W   = $clog2(RPT_MAX + 1);
            localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
            localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             phase_q, phase_d;
            logic             fire;

            // cnt holds cycles since the last press/restart/repeat, starting at 1
            // so that a match with the terminal count lands exactly on the period.
            always_comb begin
                cnt_d   = cnt_q;
                phase_d = phase_q;
                fire    = 1'b0;
                if (!sync2_q) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else if (restart_i) begin
                    cnt_d   = CNT_W'(1);
                    phase_d = 1'b0;
                end else if (cnt_q == (phase_q ? PER_C : DLY_C)) begin
                    fire    = 1'b1;
                    cnt_d   = CNT_W'(1);
                    phase_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q   <= '0;
                    phase_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    phase_q <= phase_d;
                end
            end

            assign pulse_o = rise | fire;
        end else begin : g_norpt
            logic unused_restart;
            assign unused_restart = restart_i;
            assign pulse_o        = rise;
        end
    endgenerate

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-setting controller: RUN/SET_HRS/SET_MIN FSM, 1 Hz prescaler,
// adjust pulses with auto-repeat and blink strobe for the field being set.
module time_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 1000,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_mode,
    input  logic              key_adj,
    output logic              tick_1hz,
    output logic              set_hrs_n,
    output logic              set_min_n,
    output logic              adj_hrs,
    output logic              adj_min,
    output logic              blink,
    output logic [MODE_W-1:0] mode
);

    localparam int PRESC_W    = $clog2(CLK_HZ);
    localparam int BLINK_HALF = CLK_HZ / 4;
    localparam int BLINK_W    = $clog2(BLINK_HALF);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               tick_q, tick_d;
    logic               set_hrs_n_q, set_hrs_n_d;
    logic               set_min_n_q, set_min_n_d;
    logic               adj_hrs_q, adj_hrs_d;
    logic               adj_min_q, adj_min_d;
    logic               blink_q, blink_d;
    logic               state_chg, in_run;
    logic               mode_pulse, adj_pulse;

    key_conditioner #(
        .REPEAT_EN  (1'b0),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_mode_key (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_mode),
        .restart_i (1'b0),
        .pulse_o   (mode_pulse)
    );

    key_conditioner #(
        .REPEAT_EN  (1'b1),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_adj_key (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_adj),
        .restart_i (state_chg),
        .pulse_o   (adj_pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mode_pulse) state_d = SET_HRS;
            SET_HRS: if (mode_pulse) state_d = SET_MIN;
            SET_MIN: if (mode_pulse) state_d = RUN;
            default: state_d = RUN;
        endcase
        state_chg = (state_d != state_q);
        in_run    = (state_q == RUN) && (state_d == RUN);

        // Prescaler parks at 0 outside RUN so re-entry yields a full second.
        presc_d = '0;
        tick_d  = 1'b0;
        if (in_run) begin
            if (presc_q == PRESC_MAX) begin
                tick_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        set_hrs_n_d = (state_d != SET_HRS);
        set_min_n_d = (state_d != SET_MIN);

        // A mode step in the same cycle swallows any adjust pulse.
        adj_hrs_d = adj_pulse && !state_chg && (state_q == SET_HRS);
        adj_min_d = adj_pulse && !state_chg && (state_q == SET_MIN);

        bcnt_d  = '0;
        blink_d = 1'b0;
        if ((state_d == SET_HRS) || (state_d == SET_MIN)) begin
            if (state_chg) begin
                blink_d = 1'b1;
            end else if (bcnt_q == BLINK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                blink_d = blink_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            presc_q     <= '0;
            bcnt_q      <= '0;
            tick_q      <= 1'b0;
            set_hrs_n_q <= 1'b1;
            set_min_n_q <= 1'b1;
            adj_hrs_q   <= 1'b0;
            adj_min_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            bcnt_q      <= bcnt_d;
            tick_q      <= tick_d;
            set_hrs_n_q <= set_hrs_n_d;
            set_min_n_q <= set_min_n_d;
            adj_hrs_q   <= adj_hrs_d;
            adj_min_q   <= adj_min_d;
            blink_q     <= blink_d;
        end
    end

    assign tick_1hz  = tick_q;
    assign set_hrs_n = set_hrs_n_q;
    assign set_min_n = set_min_n_q;
    assign adj_hrs   = adj_hrs_q;
    assign adj_min   = adj_min_q;
    assign blink     = blink_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random key
// activity, compared every cycle against an event-timing reference model.
module tb_time_set_ctrl;

    localparam int CLK_HZ = 8;
    localparam int DLY    = 6;
    localparam int PER    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_adj = 1'b0;
    logic       tick_1hz, set_hrs_n, set_min_n, adj_hrs, adj_min, blink;
    logic [1:0] mode;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: edge index, mode, anchors for tick/blink/repeat timing.
    int   n, m, run_start, set_start, hold;
    logic mk1, mk2, mk3, ak1, ak2, ak3;
    logic e_tick, e_adj_h, e_adj_m, e_blink;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .REPEAT_DLY (DLY),
        .REPEAT_PER (PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_adj   (key_adj),
        .tick_1hz  (tick_1hz),
        .set_hrs_n (set_hrs_n),
        .set_min_n (set_min_n),
        .adj_hrs   (adj_hrs),
        .adj_min   (adj_min),
        .blink     (blink),
        .mode      (mode)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d t=%0t", tag, obs, exp, n, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; m = 0; run_start = 0; set_start = 0; hold = -1;
        mk1 = 0; mk2 = 0; mk3 = 0; ak1 = 0; ak2 = 0; ak3 = 0;
        e_tick = 0; e_adj_h = 0; e_adj_m = 0; e_blink = 0;
    endtask

    // A key sampled high at edge k (and low at k-1) is acted on at edge k+2.
    task automatic model_edge(input logic km, input logic ka);
        int   old_m;
        logic lvl, press, mstep, rep;
        n++;
        lvl   = ak2;
        press = ak2 & ~ak3;
        mstep = mk2 & ~mk3;
        if (!lvl) hold = -1;
        rep = lvl && (hold >= 0) && ((n - hold) >= DLY) && (((n - hold - DLY) % PER) == 0);
        old_m   = m;
        e_adj_h = 0;
        e_adj_m = 0;
        if (mstep) begin
            m    = (m + 1) % 3;
            hold = lvl ? n : -1;
            if (m == 0) run_start = n;
            else        set_start = n;
        end else begin
            if (press) hold = n;
            if (press || rep) begin
                e_adj_h = (m == 1);
                e_adj_m = (m == 2);
            end
        end
        e_tick  = (m == 0) && (old_m == 0) && (n > run_start) && (((n - run_start) % CLK_HZ) == 0);
        e_blink = (m != 0) && ((((n - set_start) / (CLK_HZ / 4)) % 2) == 0);
        mk3 = mk2; mk2 = mk1; mk1 = km;
        ak3 = ak2; ak2 = ak1; ak1 = ka;
    endtask

    task automatic check_outputs();
        chk("tick_1hz",  tick_1hz,  e_tick);
        chk("set_hrs_n", set_hrs_n, (m != 1));
        chk("set_min_n", set_min_n, (m != 2));
        chk("adj_hrs",   adj_hrs,   e_adj_h);
        chk("adj_min",   adj_min,   e_adj_m);
        chk("blink",     blink,     e_blink);
        chk("mode",      mode,      2'(m));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mode"},      mode,      2'd0);
        chk({tag, "_tick"},      tick_1hz,  1'b0);
        chk({tag, "_set_hrs_n"}, set_hrs_n, 1'b1);
        chk({tag, "_set_min_n"}, set_min_n, 1'b1);
        chk({tag, "_adj_hrs"},   adj_hrs,   1'b0);
        chk({tag, "_adj_min"},   adj_min,   1'b0);
        chk({tag, "_blink"},     blink,     1'b0);
    endtask

    // Called at a negedge; drives keys, lets one posedge pass, checks, returns at negedge.
    task automatic step(input logic km, input logic ka);
        key_mode = km;
        key_adj  = ka;
        @(posedge clk);
        model_edge(km, ka);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        int         tick_cnt;
        int         dur;
        logic       km, ka, saw_adj;
        logic [20:0] adj_mask, exp_mask;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Idle RUN: ticks every CLK_HZ cycles from reset release.
        tick_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0);
            if (tick_1hz) tick_cnt++;
        end
        chk("idle_tick_count", 2'(tick_cnt == 5), 2'd1);

        // Enter SET_HRS, observe blink.
        repeat (2) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        chk("in_set_hrs", mode, 2'd1);

        // Hold adjust 15 cycles: pulses at 3, 9, 12, 15 after press.
        adj_mask = '0;
        exp_mask = '0;
        exp_mask[3] = 1'b1; exp_mask[9] = 1'b1; exp_mask[12] = 1'b1; exp_mask[15] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, (i <= 15));
            adj_mask[i] = adj_hrs;
        end
        checks++;
        assert (adj_mask === exp_mask) passed++;
        else begin
            fails++;
            $error("FAIL repeat_pattern observed=%b expected=%b", adj_mask, exp_mask);
        end

        // To SET_MIN, then mode and adjust rise together.
        repeat (2) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        chk("in_set_min", mode, 2'd2);
        saw_adj = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step((i < 3), (i < 3));
            if (adj_hrs || adj_min) saw_adj = 1'b1;
        end
        chk("same_cycle_no_adj", saw_adj, 1'b0);
        chk("same_cycle_mode", mode, 2'd0);
        repeat (10) step(1'b0, 1'b0);

        // SET_MIN auto-repeat interrupted by asynchronous reset.
        repeat (2) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        repeat (11) step(1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_vals("rst_hold");
        end
        @(negedge clk);
        key_adj = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (12) step(1'b0, 1'b0);

        // Random key activity.
        for (int seg = 0; seg < 70; seg++) begin
            dur = $urandom_range(1, 10);
            km  = ($urandom_range(0, 3) == 0);
            ka  = $urandom_range(0, 1);
            repeat (dur) step(km, ka);
        end
        repeat (10) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
